reloj_bcd_hhmmss: RTL
=====================

// Module: reloj_bcd_hhmmss
// PURPOSE
//   Time-keeping core for the digital clock. Divides the system clock to a 1 s tick and
//   keeps HH:MM:SS as six BCD digits. Supports a set mode that adjusts minutes/hours via
//   pulses. Sits directly upstream of the display digit mux, which consumes segundo1..hora2.
// PARAMETERS
//   TICK_DIV   100_000_000  clk cycles per 1 s tick (>=2); benches use 4
//   DIV_W      27           prescaler width, must hold TICK_DIV-1
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst_n      in   1  synchronous reset, active low
//   run        in   1  1 = time advances on each tick; 0 = frozen, prescaler held
//   set_mode   in   1  1 = adjust mode: prescaler held at 0, inc_min/inc_hr honoured
//   inc_min    in   1  single-cycle pulse, +1 minute (set_mode only)
//   inc_hr     in   1  single-cycle pulse, +1 hour (set_mode only)
//   segundo1   out  4  seconds units, BCD 0-9
//   segundo2   out  4  seconds tens, BCD 0-5
//   minuto1    out  4  minutes units, BCD 0-9
//   minuto2    out  4  minutes tens, BCD 0-5
//   hora1      out  4  hours units, BCD 0-9 (0-3 when hora2=2)
//   hora2      out  4  hours tens, BCD 0-2
//   tick_1hz   out  1  registered pulse, one cycle per advanced second
//   day_wrap   out  1  registered pulse, one cycle when 23:59:59 -> 00:00:00
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): all digits 0, prescaler 0, tick_1hz=0, day_wrap=0.
//     Reset wins over every other input, including mid-set or mid-carry.
//   Prescaler: counts 0..TICK_DIV-1 while run=1 and set_mode=0, then wraps to 0.
//     Held (not cleared) when run=0; forced to 0 while set_mode=1.
//   Advance: on the edge where prescaler==TICK_DIV-1 (and counting), time += 1 s.
//     tick_1hz is high for the cycle after that edge, coincident with the new digits.
//   Carry chain, all on the same edge:
//     seg1 9->0 carries to seg2; seg2 5->0 carries to min1; min1 9->0 to min2;
//     min2 5->0 to hours. Hours roll as a pair: 09->10, 19->20, 23->00.
//   day_wrap: high for exactly the cycle where tick_1hz reports 00:00:00 after 23:59:59.
//   Set mode (set_mode=1, run ignored):
//     inc_min: minutes +1 mod 60, no carry into hours; seconds cleared to 00.
//     inc_hr: hours +1 mod 24 (23->00), minutes/seconds untouched.
//     Both in one cycle: both applied; seconds cleared.
//     tick_1hz and day_wrap stay 0 in set mode.
//   inc_min/inc_hr outside set mode are ignored.
//   Leaving set mode: prescaler restarts at 0, so the first tick is TICK_DIV cycles later.
//   Held pulses: each cycle with inc_* high counts as one increment. Debouncing and edge
//     detection are upstream.
//   Digits are always legal BCD; no state reachable from reset produces values >9.
//   Outputs come straight from registers, with no combinational path from inputs.
// TESTING (TICK_DIV=4)
//   1 reset: rst_n=0 for 2 cycles mid-count -> all digits 0, tick_1hz=0 on the next cycle.
//   2 basic tick: run=1 for 40 cycles from 00:00:00 -> tick_1hz every 4th cycle;
//     time reads 00:00:10, seg2=1, seg1=0.
//   3 full wrap: set 23:59:58, run 8 cycles -> 23:59:59, then 00:00:00 with day_wrap=1
//     for exactly one cycle.
//   4 hour tens: from 09:59:59 one tick -> 10:00:00; from 19:59:59 -> 20:00:00.
//   5 set mode: from 12:34:56, set_mode=1, inc_min x26 -> 12:00:00, hours unchanged;
//     inc_hr x12 -> 00:00:00; simultaneous inc_min+inc_hr at 00:00:30 -> 01:01:00.
//   6 freeze: run=0 at prescaler=2 for 10 cycles -> no tick; after run=1 the tick
//     comes 2 cycles later.

Source files
------------

// File: rtl/reloj_bcd_hhmmss.sv
// reloj_bcd_hhmmss: HH:MM:SS time-keeping core with 1 s prescaler and set mode.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   run                time advances on each tick when high (ignored in set mode)
//   set_mode           adjust mode: prescaler forced to 0, inc_min/inc_hr honoured
//   inc_min, inc_hr    per-cycle increment requests (set mode only)
//   segundo1..hora2    six BCD digits, registered
//   tick_1hz           one-cycle pulse coincident with each advanced second
//   day_wrap           one-cycle pulse when 23:59:59 rolls to 00:00:00
module reloj_bcd_hhmmss #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned DIV_W    = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [3:0] segundo1,
    output logic [3:0] segundo2,
    output logic [3:0] minuto1,
    output logic [3:0] minuto2,
    output logic [3:0] hora1,
    output logic [3:0] hora2,
    output logic       tick_1hz,
    output logic       day_wrap
);

    localparam int unsigned DIG_W = 4;

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIG_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [DIG_W-1:0] m1_q, m1_d, m2_q, m2_d;
    logic [DIG_W-1:0] h1_q, h1_d, h2_q, h2_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    logic             last_cnt;
    logic             sec_carry;
    logic             min_carry;
    logic             hr_max;

    // Minutes +1 modulo 60 as a BCD pair {tens, units}.
    function automatic logic [2*DIG_W-1:0] next_min(input logic [DIG_W-1:0] tens,
                                                    input logic [DIG_W-1:0] units);
        logic [DIG_W-1:0] t;
        logic [DIG_W-1:0] u;
        t = tens;
        u = units;
        if (units == DIG_W'(9)) begin
            u = '0;
            t = (tens == DIG_W'(5)) ? '0 : tens + DIG_W'(1);
        end else begin
            u = units + DIG_W'(1);
        end
        return {t, u};
    endfunction

    // Hours +1 modulo 24 as a BCD pair {tens, units}.
    function automatic logic [2*DIG_W-1:0] next_hr(input logic [DIG_W-1:0] tens,
                                                   input logic [DIG_W-1:0] units);
        logic [DIG_W-1:0] t;
        logic [DIG_W-1:0] u;
        t = tens;
        u = units;
        if (tens == DIG_W'(2) && units == DIG_W'(3)) begin
            t = '0;
            u = '0;
        end else if (units == DIG_W'(9)) begin
            t = tens + DIG_W'(1);
            u = '0;
        end else begin
            u = units + DIG_W'(1);
        end
        return {t, u};
    endfunction

    assign last_cnt  = (presc_q == DIV_W'(TICK_DIV - 1));
    assign sec_carry = (s1_q == DIG_W'(9)) && (s2_q == DIG_W'(5));
    assign min_carry = (m1_q == DIG_W'(9)) && (m2_q == DIG_W'(5));
    assign hr_max    = (h2_q == DIG_W'(2)) && (h1_q == DIG_W'(3));

    // Next-state: set-mode adjustments, or prescaler plus carry chain.
    always_comb begin
        presc_d = presc_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        h1_d    = h1_q;
        h2_d    = h2_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (set_mode) begin
            presc_d = '0;
            if (inc_min) begin
                {m2_d, m1_d} = next_min(m2_q, m1_q);
                s1_d = '0;
                s2_d = '0;
            end
            if (inc_hr) begin
                {h2_d, h1_d} = next_hr(h2_q, h1_q);
            end
        end else if (run) begin
            if (last_cnt) begin
                presc_d = '0;
                tick_d  = 1'b1;
                wrap_d  = sec_carry && min_carry && hr_max;
                if (s1_q == DIG_W'(9)) begin
                    s1_d = '0;
                    s2_d = (s2_q == DIG_W'(5)) ? '0 : s2_q + DIG_W'(1);
                end else begin
                    s1_d = s1_q + DIG_W'(1);
                end
                if (sec_carry) begin
                    {m2_d, m1_d} = next_min(m2_q, m1_q);
                end
                if (sec_carry && min_carry) begin
                    {h2_d, h1_d} = next_hr(h2_q, h1_q);
                end
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            h1_q    <= '0;
            h2_q    <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign segundo1 = s1_q;
    assign segundo2 = s2_q;
    assign minuto1  = m1_q;
    assign minuto2  = m2_q;
    assign hora1    = h1_q;
    assign hora2    = h2_q;
    assign tick_1hz = tick_q;
    assign day_wrap = wrap_q;

endmodule
